// File: rtl/data_bus_responder_if.sv
// Core-to-responder data bus: store strobe, byte address, store data and
// combinational load data. The core is master, the responder is slave.
interface data_bus_responder_if;
   logic        dataWe;
   logic [31:0] dataAddr;
   logic [31:0] dataWData;
   logic [31:0] dataRData;

   modport master (output dataWe, output dataAddr, output dataWData, input dataRData);
   modport slave  (input dataWe, input dataAddr, input dataWData, output dataRData);
endinterface

// File: rtl/data_bus_responder.sv
// Data-side target of the RV32I core: word RAM plus GPO/GPI/ID MMIO, with an
// optional compare timer enabled by defining DBR_TIMER_EN.
module data_bus_responder #(
   parameter int          RAM_AW   = 8,
   parameter int          GPI_W    = 8,
   parameter logic [31:0] ID_VALUE = 32'h5256_3332
) (
   input  logic                 clk,
   input  logic                 reset,
   data_bus_responder_if.slave  bus,
   input  logic [GPI_W-1:0]     gpi,
   output logic [GPI_W-1:0]     gpo,
   output logic                 timer_irq
);
   localparam logic [7:0] OFF_GPO = 8'h00;
   localparam logic [7:0] OFF_GPI = 8'h04;
   localparam logic [7:0] OFF_ID  = 8'h14;

   logic              ram_sel;
   logic              mmio_sel;
   logic              mmio_we;
   logic [7:0]        off;
   logic [RAM_AW-1:0] ram_idx;
   logic [31:0]       mem [2**RAM_AW];
   logic [GPI_W-1:0]  gpi_meta;
   logic [GPI_W-1:0]  gpi_sync;
   logic              unused_addr_bits;

   assign ram_sel          = (bus.dataAddr[31:28] == 4'h0);
   assign mmio_sel         = (bus.dataAddr[31:28] == 4'h1) && (bus.dataAddr[27:8] == 20'h0);
   assign mmio_we          = bus.dataWe && mmio_sel;
   assign off              = bus.dataAddr[7:0];
   assign ram_idx          = bus.dataAddr[RAM_AW+1:2];
   assign unused_addr_bits = ^bus.dataAddr[1:0];

   // NOTE: the RAM array has no reset branch so it maps onto plain memory
   // macros; stores made while reset is high still land.
   always_ff @(posedge clk) begin
      if (bus.dataWe && ram_sel) mem[ram_idx] <= bus.dataWData;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         gpo      <= '0;
         gpi_meta <= '0;
         gpi_sync <= '0;
      end else begin
         gpi_meta <= gpi;
         gpi_sync <= gpi_meta;
         if (mmio_we && off == OFF_GPO) gpo <= bus.dataWData[GPI_W-1:0];
      end
   end

`ifdef DBR_TIMER_EN
   localparam logic [7:0] OFF_TCNT  = 8'h08;
   localparam logic [7:0] OFF_TCMP  = 8'h0C;
   localparam logic [7:0] OFF_TCTRL = 8'h10;

   logic [31:0] tcnt;
   logic [31:0] tcmp;
   logic        t_en;
   logic        t_irq_en;
   logic        t_match;
   logic        match_hit;

   assign match_hit = t_en && (tcnt == tcmp);
   assign timer_irq = t_match && t_irq_en;

   // NOTE: non-blocking assignments let later statements override earlier ones
   // for the same register: MATCH set beats W1C, and a core TCNT write beats
   // the count. match_hit reads the pre-edge EN, so a TCTRL write only takes
   // effect on the following cycle's count decision.
   always_ff @(posedge clk) begin
      if (reset) begin
         tcnt     <= 32'h0;
         tcmp     <= 32'h0;
         t_en     <= 1'b0;
         t_irq_en <= 1'b0;
         t_match  <= 1'b0;
      end else begin
         if (mmio_we && off == OFF_TCTRL) begin
            t_en     <= bus.dataWData[0];
            t_irq_en <= bus.dataWData[1];
            if (bus.dataWData[2]) t_match <= 1'b0;
         end
         if (match_hit) begin
            tcnt    <= 32'h0;
            t_match <= 1'b1;
         end else if (t_en) begin
            tcnt <= tcnt + 32'h1;
         end
         if (mmio_we && off == OFF_TCNT) tcnt <= bus.dataWData;
         if (mmio_we && off == OFF_TCMP) tcmp <= bus.dataWData;
      end
   end
`else
   assign timer_irq = 1'b0;
`endif

   // NOTE: default assignment first so every path drives dataRData and no
   // latch is inferred.
   always_comb begin
      bus.dataRData = 32'h0;
      if (ram_sel) begin
         bus.dataRData = mem[ram_idx];
      end else if (mmio_sel) begin
         case (off)
            OFF_GPO:   bus.dataRData = 32'(gpo);
            OFF_GPI:   bus.dataRData = 32'(gpi_sync);
`ifdef DBR_TIMER_EN
            OFF_TCNT:  bus.dataRData = tcnt;
            OFF_TCMP:  bus.dataRData = tcmp;
            OFF_TCTRL: bus.dataRData = {29'h0, t_match, t_irq_en, t_en};
`endif
            OFF_ID:    bus.dataRData = ID_VALUE;
            default:   bus.dataRData = 32'h0;
         endcase
      end
   end
endmodule
